stopwatch_core: RTL

//   Timing core of the DE10-Lite stopwatch, directly upstream of the HEX decode stage in stopwatch_top.

---
 rtl/stopwatch_core.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// stopwatch_core -- timing core of the DE10-Lite stopwatch.
//   Conditions the two push keys, runs an IDLE/RUN/PAUSE FSM and counts a
//   BCD MM:SS value (00:00..59:59, wraps) at TICK_HZ derived from CLK_HZ.
//   Optional debounce: define STOPWATCH_DEBOUNCE_EN to require
//   DEBOUNCE_CYCLES of stable synchronised level before a key change is
//   accepted; otherwise the synchroniser output is used directly.
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   reset         in   synchronous, active-high
//   KEY[1:0]      in   raw active-low keys; [0] start/pause, [1] clear
//   running       out  1 while in RUN
//   tick          out  one-cycle pulse, coincident with each digit increment
//   bcd_sec_ones  out  0..9     bcd_sec_tens  out  0..5
//   bcd_min_ones  out  0..9     bcd_min_tens  out  0..5

// Per-key conditioner: 2-flop sync, optional debounce, press (1->0) detect.
// A press is only reported once the key has been seen released after reset,
// so a key held down through reset release never generates a pulse.
module stopwatch_key_cond #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);
  logic       r_sync1, r_sync2, r_lvl_d, r_armed;
  logic [1:0] r_settle;
  logic       w_lvl;

  // r_settle covers the two cycles in which r_sync2 still holds its reset
  // value rather than a real sample of the key.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_lvl_d  <= 1'b1;
      r_armed  <= 1'b0;
      r_settle <= 2'd0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_lvl_d <= w_lvl;
      if (r_settle != 2'd2) r_settle <= r_settle + 2'd1;
      else if (r_sync2)     r_armed  <= 1'b1;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_deb;

  // Count consecutive cycles the synchronised level disagrees with the
  // accepted level; any agreement restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_deb <= 1'b1;
    end else if (r_sync2 != r_deb) begin
      if (r_cnt == CNT_MAX) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_cnt <= '0;
    end
  end
  assign w_lvl = r_deb;
`else
  assign w_lvl = r_sync2;
`endif

  assign o_press = r_armed & r_lvl_d & ~w_lvl;
endmodule

module stopwatch_core #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] KEY,
  output logic       running,
  output logic       tick,
  output logic [3:0] bcd_sec_ones,
  output logic [3:0] bcd_sec_tens,
  output logic [3:0] bcd_min_ones,
  output logic [3:0] bcd_min_tens
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [1:0]    w_press;
  logic          w_start, w_clear;

  for (genvar g = 0; g < 2; g++) begin : g_key
    stopwatch_key_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .i_clk   (CLOCK_50),
      .i_rst   (reset),
      .i_key_n (KEY[g]),
      .o_press (w_press[g])
    );
  end

  assign w_start = w_press[0];
  assign w_clear = w_press[1];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      running      <= 1'b0;
      tick         <= 1'b0;
      bcd_sec_ones <= 4'd0;
      bcd_sec_tens <= 4'd0;
      bcd_min_ones <= 4'd0;
      bcd_min_tens <= 4'd0;
    end else begin
      tick <= 1'b0;
      // Clear beats start and beats a count landing on the same edge.
      if (w_clear) begin
        r_state      <= S_IDLE;
        r_presc      <= '0;
        running      <= 1'b0;
        bcd_sec_ones <= 4'd0;
        bcd_sec_tens <= 4'd0;
        bcd_min_ones <= 4'd0;
        bcd_min_tens <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_presc      <= '0;
            bcd_sec_ones <= 4'd0;
            bcd_sec_tens <= 4'd0;
            bcd_min_ones <= 4'd0;
            bcd_min_tens <= 4'd0;
            if (w_start) begin
              r_state <= S_RUN;
              running <= 1'b1;
            end
          end
          S_RUN: begin
            // The pause edge itself does not count, so the prescaler keeps
            // the fractional second exactly as seen on that edge.
            if (w_start) begin
              r_state <= S_PAUSE;
              running <= 1'b0;
            end else if (r_presc == PMAX) begin
              r_presc <= '0;
              tick    <= 1'b1;
              if (bcd_sec_ones != 4'd9) bcd_sec_ones <= bcd_sec_ones + 4'd1;
              else begin
                bcd_sec_ones <= 4'd0;
                if (bcd_sec_tens != 4'd5) bcd_sec_tens <= bcd_sec_tens + 4'd1;
                else begin
                  bcd_sec_tens <= 4'd0;
                  if (bcd_min_ones != 4'd9) bcd_min_ones <= bcd_min_ones + 4'd1;
                  else begin
                    bcd_min_ones <= 4'd0;
                    if (bcd_min_tens != 4'd5) bcd_min_tens <= bcd_min_tens + 4'd1;
                    else                      bcd_min_tens <= 4'd0;
                  end
                end
              end
            end else begin
              r_presc <= r_presc + 1'b1;
            end
          end
          S_PAUSE: begin
            if (w_start) begin
              r_state <= S_RUN;
              running <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            running <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
